cubroot_arbiter: RTL and testbench

- Shares one cubroot datapath instance (8-bit integer cube root) between N_REQ independent requesters.
- Fair round-robin grant, per-requester req/ack handshake, broadcast result bus with a per-requester done strobe.
- Sits between client blocks and the single cubroot instance, which it owns and sequences.

---
 rtl/cubroot_pkg.sv | 16 +
 rtl/cubroot.sv | 42 ++++
 rtl/cubroot_arbiter_rr_pick.sv | 29 ++
 rtl/cubroot_arbiter.sv | 96 +++++++++
 tb/tb_cubroot_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cubroot_pkg.sv
// Shared types and widths for the cubroot arbiter slice.
// Imported by the arbiter, the round-robin picker and the datapath.
package cubroot_pkg;

    localparam int CBRT_W    = 8;
    localparam int OPS_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        RUN,
        DONE
    } arb_state_t;

endpackage

// File: rtl/cubroot.sv
// Iterative 8-bit integer cube root datapath (synchronous reset).
// busy_o rises on the edge that accepts start_i and falls when y_bo is final.
import cubroot_pkg::*;

module cubroot (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CBRT_W-1:0] x_bi,
    output logic              busy_o,
    output logic [CBRT_W-1:0] y_bo
);

    logic [CBRT_W-1:0] x_q;
    logic [2:0]        y_q;
    logic [3:0]        y_nxt;
    logic [11:0]       cube;

    assign y_nxt = {1'b0, y_q} + 4'd1;
    assign cube  = {8'd0, y_nxt} * {8'd0, y_nxt} * {8'd0, y_nxt};
    assign y_bo  = {5'd0, y_q};

    // Walk y upward while (y+1)^3 still fits under x.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (start_i && !busy_o) begin
            busy_o <= 1'b1;
            x_q    <= x_bi;
            y_q    <= '0;
        end else if (busy_o) begin
            if (cube <= {4'd0, x_q}) begin
                y_q <= y_nxt[2:0];
            end else begin
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cubroot_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i.
// Lowest offset from the pointer wins, wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          valid_o,
    output logic [PW-1:0] idx_o
);

    int j;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/cubroot_arbiter.sv
// Round-robin arbiter sharing one cubroot datapath among N_REQ clients.
// ack_o pulses in LAUNCH, done_o pulses in DONE together with a valid y_o.
import cubroot_pkg::*;

module cubroot_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [CBRT_W*N_REQ-1:0]   x_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [N_REQ-1:0]          done_o,
    output logic [CBRT_W-1:0]         y_o,
    output logic                      busy_o,
    output logic [OPS_CNT_W-1:0]      ops_cnt_o
);

    arb_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, owner_q, pick_idx, ptr_nxt;
    logic                pick_valid;
    logic [CBRT_W-1:0]   x_q, sel_x, cb_y;
    logic                cb_start, cb_busy, grant, finish;
    logic [OPS_CNT_W-1:0] ops_cnt_q;

    rr_pick #(.N(N_REQ)) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .valid_o(pick_valid),
        .idx_o  (pick_idx)
    );

    cubroot u_cbrt (
        .clk_i  (clk_i),
        .rst_i  (~rst_ni),
        .start_i(cb_start),
        .x_bi   (x_q),
        .busy_o (cb_busy),
        .y_bo   (cb_y)
    );

    assign sel_x   = x_i[CBRT_W*int'(pick_idx) +: CBRT_W];
    assign ptr_nxt = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign grant   = (state_q == IDLE) && pick_valid;
    assign finish  = (state_q == RUN) && !cb_busy;

    always_comb begin
        state_d  = state_q;
        cb_start = 1'b0;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = LAUNCH;
            LAUNCH: begin
                cb_start = 1'b1;
                state_d  = SETTLE;
            end
            SETTLE:  state_d = RUN;
            RUN:     if (!cb_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered on the edge entering LAUNCH/DONE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            x_q       <= '0;
            ack_o     <= '0;
            done_o    <= '0;
            y_o       <= '0;
            ops_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ack_o   <= '0;
            done_o  <= '0;
            if (grant) begin
                x_q     <= sel_x;
                owner_q <= pick_idx;
                ptr_q   <= ptr_nxt;
                ack_o   <= N_REQ'(1) << pick_idx;
            end
            if (finish) begin
                y_o       <= cb_y;
                done_o    <= N_REQ'(1) << owner_q;
                ops_cnt_q <= ops_cnt_q + 1'b1;
            end
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign ops_cnt_o = ops_cnt_q;

endmodule

// File: tb/tb_cubroot_arbiter.sv
// Directed bench for cubroot_arbiter: grants, results, fairness, reset, wrap.
// Outputs are sampled on the falling clock edge.
module tb_cubroot_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  req;
    logic [31:0] x;
    logic [3:0]  ack, done;
    logic [7:0]  y;
    logic        busy;
    logic [15:0] ops;

    int n_chk = 0;
    int n_bad = 0;
    int gcnt [4];
    int prev_idx;

    always #5 clk = ~clk;

    cubroot_arbiter #(.N_REQ(4)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .req_i    (req),
        .x_i      (x),
        .ack_o    (ack),
        .done_o   (done),
        .y_o      (y),
        .busy_o   (busy),
        .ops_cnt_o(ops)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Wait for a grant to k, optionally drop its request, then wait for done.
    task automatic serve(input int k, input logic [7:0] exp_y,
                         input bit drop, input string tag);
        int n;
        int gap;
        logic [3:0] oh;
        oh = 4'b0001 << k;
        n = 0;
        gap = 0;
        @(negedge clk);
        while (ack == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack"}, {28'd0, ack}, {28'd0, oh});
        chk({tag, "_busy_ack"}, {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) if (ack[i]) gcnt[i]++;
        if (drop) req[k] = 1'b0;
        n = 0;
        @(negedge clk);
        while (done == 4'b0 && n < 40) begin
            if (!busy || ack != 4'b0) gap++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, {28'd0, done}, {28'd0, oh});
        chk({tag, "_y"}, {24'd0, y}, {24'd0, exp_y});
        chk({tag, "_busy_gap"}, gap, 32'd0);
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic single(input int k, input logic [7:0] xv,
                          input logic [7:0] exp_y, input string tag);
        x[8*k +: 8] = xv;
        req[k] = 1'b1;
        serve(k, exp_y, 1'b1, tag);
    endtask

    initial begin
        int k;
        rst_ni = 1'b0;
        req = '0;
        x = '0;
        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        chk("rst_ops", {16'd0, ops}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        single(0, 8'd27, 8'd3, "single27");
        chk("single_ops", {16'd0, ops}, 32'd1);

        single(2, 8'd0, 8'd0, "bnd0");
        single(2, 8'd1, 8'd1, "bnd1");
        single(2, 8'd64, 8'd4, "bnd64");
        single(2, 8'd125, 8'd5, "bnd125");
        single(2, 8'd216, 8'd6, "bnd216");
        single(2, 8'd255, 8'd6, "bnd255");
        chk("bnd_ops", {16'd0, ops}, 32'd7);

        do_reset();
        x = {8'd125, 8'd64, 8'd27, 8'd8};
        req = 4'b1111;
        serve(0, 8'd2, 1'b1, "all0");
        serve(1, 8'd3, 1'b1, "all1");
        serve(2, 8'd4, 1'b1, "all2");
        serve(3, 8'd5, 1'b1, "all3");
        chk("all_ops", {16'd0, ops}, 32'd4);

        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        req = 4'b1111;
        prev_idx = -1;
        for (int i = 0; i < 12; i++) begin
            k = i % 4;
            serve(k, (k == 0) ? 8'd2 : (k == 1) ? 8'd3 :
                     (k == 2) ? 8'd4 : 8'd5, 1'b0, "fair");
            chk("fair_noconsec", {31'd0, k != prev_idx}, 32'd1);
            prev_idx = k;
        end
        req = '0;
        for (int i = 0; i < 4; i++) chk("fair_cnt", gcnt[i], 32'd3);
        @(negedge clk);
        @(negedge clk);

        x[15:8] = 8'd255;
        req[1] = 1'b1;
        k = 0;
        @(negedge clk);
        while (ack == 4'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("mid_ack", {28'd0, ack}, 32'd2);
        req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_ack0", {28'd0, ack}, 32'd0);
        chk("mid_done", {28'd0, done}, 32'd0);
        chk("mid_y", {24'd0, y}, 32'd0);
        chk("mid_ops", {16'd0, ops}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done != 4'b0) k++;
        end
        chk("mid_nodone", k, 32'd0);
        single(1, 8'd64, 8'd4, "post64");

        @(negedge clk);
        force dut.ops_cnt_q = 16'hFFFF;
        #1;
        release dut.ops_cnt_q;
        single(3, 8'd8, 8'd2, "wrap");
        chk("wrap_ops", {16'd0, ops}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
